spi_flash_stream_reader: RTL

- Autonomous master sitting directly upstream of the SPI controller, on that controller's register/buffer write port.
- Drives that port on behalf of the boot/prefetch logic: loads a flash read command into the TX buffer, runs the command and data transfers with flash chip-select held, exposes the RX half, then streams the received bytes out as 16-bit words over a valid/ready interface.
- Lets the cartridge fill RAM from SPI flash without the host CPU polling SPI_CNT.

---
 rtl/spi_flash_stream_reader.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_stream_reader.sv
// rtl/spi_flash_stream_reader.sv - autonomous SPI flash read master streaming 16-bit words
// Optional: define SPI_FAST_READ_EN for 0x0B fast read with one dummy header byte.
module spi_flash_stream_reader #(
  parameter int RD_LATENCY = 2,
  parameter int POLL_GAP   = 4
) (
  input  logic        FastClk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [23:0] FlashAddr,
  input  logic [8:0]  ByteCount,
  output logic        Idle,
  output logic        SpiWrStb,
  output logic        SpiWrTx,
  output logic        SpiWrCntLo,
  output logic        SpiWrCntHi,
  output logic [8:0]  SpiBufAddr,
  output logic [7:0]  SpiWrData,
  output logic        SpiRdStb,
  input  logic [15:0] SpiCntIn,
  input  logic [15:0] RxData,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] OutData,
  output logic        OutLast
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD_OP   = 8'h0B;
  localparam logic [3:0] HDR_LAST = 4'd4;
  localparam logic [7:0] CMD_LEN  = 8'h04;
`else
  localparam logic [7:0] CMD_OP   = 8'h03;
  localparam logic [3:0] HDR_LAST = 4'd3;
  localparam logic [7:0] CMD_LEN  = 8'h03;
`endif
  localparam logic [7:0] RD_WAIT  = 8'(RD_LATENCY);
  localparam logic [7:0] GAP_WAIT = 8'(POLL_GAP);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ARM_CMD, S_WAIT_CMD, S_ARM_READ, S_WAIT_READ, S_SWAP, S_STREAM, S_DESEL
  } state_t;
  typedef enum logic [1:0] {WR_NONE, WR_TX, WR_LO, WR_HI} wr_sel_t;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [7:0]  wait_q, wait_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  bc_q, bc_d;
  logic [7:0]  word_q, word_d;
  logic        idle_q, idle_d;
  logic        wr_stb_q, wr_stb_d, wr_tx_q, wr_tx_d, wr_lo_q, wr_lo_d, wr_hi_q, wr_hi_d;
  logic [8:0]  buf_addr_q, buf_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rd_stb_q, rd_stb_d;
  logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [15:0] out_data_q, out_data_d;
  wr_sel_t     wr_sel;
  logic [7:0]  wr_val;
  logic        unused_cnt;

  assign unused_cnt = ^SpiCntIn[14:0];

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [23:0] a);
    case (idx)
      3'd0:    return CMD_OP;
      3'd1:    return a[23:16];
      3'd2:    return a[15:8];
      3'd3:    return a[7:0];
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    bc_d        = bc_q;
    word_d      = word_q;
    wr_stb_d    = 1'b0;
    wr_tx_d     = 1'b0;
    wr_lo_d     = 1'b0;
    wr_hi_d     = 1'b0;
    buf_addr_d  = buf_addr_q;
    wr_data_d   = wr_data_q;
    rd_stb_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    wr_sel      = WR_NONE;
    wr_val      = 8'h00;
    // Every strobe and every poll sample is followed by a countdown; nothing else moves meanwhile.
    if (wait_q != 8'd0) begin
      wait_d = wait_q - 8'd1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            addr_d  = FlashAddr;
            bc_d    = ByteCount;
            state_d = S_LOAD;
            step_d  = 4'd0;
          end
        end
        S_LOAD: begin
          wr_sel = WR_TX;
          wr_val = hdr_byte(step_q[2:0], addr_q);
          if (step_q == HDR_LAST) begin
            state_d = S_ARM_CMD;
            step_d  = 4'd0;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        S_ARM_CMD: begin
          if (step_q == 4'd0) begin
            wr_sel = WR_LO;
            wr_val = CMD_LEN;
            step_d = 4'd1;
          end else begin
            wr_sel  = WR_HI;
            wr_val  = 8'hA0;
            state_d = S_WAIT_CMD;
            step_d  = 4'd0;
          end
        end
        S_ARM_READ: begin
          if (step_q == 4'd0) begin
            wr_sel = WR_LO;
            wr_val = bc_q[7:0];
            step_d = 4'd1;
          end else begin
            wr_sel  = WR_HI;
            wr_val  = {7'b1010_001, bc_q[8]};
            state_d = S_WAIT_READ;
            step_d  = 4'd0;
          end
        end
        S_SWAP: begin
          wr_sel  = WR_HI;
          wr_val  = {7'b0110_000, bc_q[8]};
          state_d = S_STREAM;
          step_d  = 4'd0;
          word_d  = 8'd0;
        end
        S_STREAM: begin
          if (step_q == 4'd0) begin
            rd_stb_d   = 1'b1;
            buf_addr_d = {word_q, 1'b0};
            wait_d     = RD_WAIT;
            step_d     = 4'd1;
          end else if (step_q == 4'd1) begin
            out_valid_d = 1'b1;
            out_data_d  = RxData;
            out_last_d  = (word_q == bc_q[8:1]);
            step_d      = 4'd2;
          end else if (out_valid_q && OutReady) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            step_d      = 4'd0;
            if (word_q == bc_q[8:1]) state_d = S_DESEL;
            else word_d = word_q + 8'd1;
          end
        end
        S_WAIT_CMD, S_WAIT_READ, S_DESEL: begin
          // DESEL shares the busy poll so a transfer left running by a reset completes first.
          if (step_q == 4'd0) begin
            rd_stb_d = 1'b1;
            wait_d   = RD_WAIT;
            step_d   = 4'd1;
          end else if (step_q == 4'd1) begin
            if (SpiCntIn[15]) begin
              wait_d = GAP_WAIT;
              step_d = 4'd0;
            end else if (state_q == S_WAIT_CMD) begin
              state_d = S_ARM_READ;
              step_d  = 4'd0;
            end else if (state_q == S_WAIT_READ) begin
              state_d = S_SWAP;
              step_d  = 4'd0;
            end else begin
              step_d = 4'd2;
            end
          end else if (step_q == 4'd2) begin
            wr_sel = WR_HI;
            wr_val = 8'h00;
            step_d = 4'd3;
          end else begin
            state_d = S_IDLE;
            step_d  = 4'd0;
          end
        end
        default: begin
          state_d = S_DESEL;
          step_d  = 4'd0;
        end
      endcase
    end
    if (wr_sel != WR_NONE) begin
      wr_stb_d  = 1'b1;
      wr_tx_d   = (wr_sel == WR_TX);
      wr_lo_d   = (wr_sel == WR_LO);
      wr_hi_d   = (wr_sel == WR_HI);
      wr_data_d = wr_val;
      wait_d    = 8'd1;
      if (wr_sel == WR_TX) buf_addr_d = {5'd0, step_q};
    end
    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge FastClk) begin
    if (Reset) begin
      state_q     <= S_DESEL;
      step_q      <= 4'd0;
      wait_q      <= 8'd0;
      addr_q      <= 24'd0;
      bc_q        <= 9'd0;
      word_q      <= 8'd0;
      idle_q      <= 1'b1;
      wr_stb_q    <= 1'b0;
      wr_tx_q     <= 1'b0;
      wr_lo_q     <= 1'b0;
      wr_hi_q     <= 1'b0;
      buf_addr_q  <= 9'd0;
      wr_data_q   <= 8'd0;
      rd_stb_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      bc_q        <= bc_d;
      word_q      <= word_d;
      idle_q      <= idle_d;
      wr_stb_q    <= wr_stb_d;
      wr_tx_q     <= wr_tx_d;
      wr_lo_q     <= wr_lo_d;
      wr_hi_q     <= wr_hi_d;
      buf_addr_q  <= buf_addr_d;
      wr_data_q   <= wr_data_d;
      rd_stb_q    <= rd_stb_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign Idle       = idle_q;
  assign SpiWrStb   = wr_stb_q;
  assign SpiWrTx    = wr_tx_q;
  assign SpiWrCntLo = wr_lo_q;
  assign SpiWrCntHi = wr_hi_q;
  assign SpiBufAddr = buf_addr_q;
  assign SpiWrData  = wr_data_q;
  assign SpiRdStb   = rd_stb_q;
  assign OutValid   = out_valid_q;
  assign OutData    = out_data_q;
  assign OutLast    = out_last_q;

endmodule
